lock_controller: RTL

Top-level sequencing FSM for the keypad lock. It owns the lock state (open / closed / blocked) and the wrong-password count. After MAX_ERRORS consecutive failed attempts it enforces a timed lockout. It consumes the comparator result `senha_ok` and the confirm button `B`, and drives the state code used by the display and actuator logic.

---
 rtl/lock_pkg.sv | 11 +
 rtl/lockout_timer.sv | 32 +++
 rtl/lock_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared encodings for the keypad lock: state codes and field widths.
package lock_pkg;

    localparam int STATE_W = 2;
    localparam int ERR_W   = 2;

    localparam logic [STATE_W-1:0] AB = 2'b00;
    localparam logic [STATE_W-1:0] FE = 2'b01;
    localparam logic [STATE_W-1:0] BL = 2'b10;

endpackage

// File: rtl/lockout_timer.sv
// Lockout down-counter: load presets LOCK_CYCLES-1, enable decrements, saturating at 0.
// Latency: zero flag is combinational from the registered count.
// Backpressure: none; load and enable are sampled every cycle.
module lockout_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic zero
);

    // A one-cycle lockout still needs a 1-bit register.
    localparam int              W        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [W-1:0]    LOAD_VAL = W'(LOCK_CYCLES - 1);

    logic [W-1:0] cnt;

    assign zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (enable && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: open/closed/blocked state, failed-attempt count, timed lockout.
// Latency: a press or close detected at edge N updates all outputs at edge N.
// Backpressure: none; B and fechar are edge-detected levels, held levels give one event.
module lock_controller
    import lock_pkg::*;
#(
    parameter int MAX_ERRORS  = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               B,
    input  logic               senha_ok,
    input  logic               fechar,
    output logic [STATE_W-1:0] state,
    output logic [ERR_W-1:0]   error_count,
    output logic               erro,
    output logic               travado,
    output logic               aberto
);

    localparam logic [ERR_W-1:0] MAX_CNT = ERR_W'(MAX_ERRORS);

    logic               b_q;
    logic               f_q;
    logic               press;
    logic               close;
    logic [STATE_W-1:0] state_nxt;
    logic [ERR_W-1:0]   cnt_nxt;
    logic [ERR_W-1:0]   cnt_inc;
    logic               erro_nxt;
    logic               tmr_load;
    logic               tmr_zero;

    assign press = B & ~b_q;
    assign close = fechar & ~f_q;

    lockout_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .enable (state == BL),
        .zero   (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = error_count;
        erro_nxt  = 1'b0;
        tmr_load  = 1'b0;
        // Saturating increment: the count never wraps past MAX_ERRORS.
        cnt_inc   = (error_count < MAX_CNT) ? error_count + 1'b1 : error_count;
        case (state)
            FE: begin
                if (press) begin
                    if (senha_ok) begin
                        state_nxt = AB;
                        cnt_nxt   = '0;
                    end else begin
                        erro_nxt = 1'b1;
                        cnt_nxt  = cnt_inc;
                        if (cnt_inc == MAX_CNT) begin
                            state_nxt = BL;
                            tmr_load  = 1'b1;
                        end
                    end
                end
            end
            AB: begin
                cnt_nxt = '0;
                if (close) begin
                    state_nxt = FE;
                end
            end
            BL: begin
                cnt_nxt = MAX_CNT;
                if (tmr_zero) begin
                    state_nxt = FE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = FE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Edge-detect registers preset high so a level held through reset is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q         <= 1'b1;
            f_q         <= 1'b1;
            state       <= FE;
            error_count <= '0;
            erro        <= 1'b0;
            travado     <= 1'b0;
            aberto      <= 1'b0;
        end else begin
            b_q         <= B;
            f_q         <= fechar;
            state       <= state_nxt;
            error_count <= cnt_nxt;
            erro        <= erro_nxt;
            travado     <= (state_nxt == BL);
            aberto      <= (state_nxt == AB);
        end
    end

endmodule
